// File: rtl/fpu_pkg.sv
// Shared FP32 unit definitions: sequencer states, format constants, exponent adder.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MANT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [7:0]  BIAS    = 8'd127;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam int          MANT_W  = 24;

    // Ripple 8-bit full adder; the carry-out lands in bit 8.
    function automatic logic [8:0] add8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [7:0] s;
        logic       c;
        c = cin;
        for (int i = 0; i < 8; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

endpackage

// File: rtl/mul_f_32bit_if.sv
// Issue/result bundle shared by the FP32 multiplier and divider.
interface mul_f_32bit_if;
    logic        start;
    logic        stop;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Mul_f;
    logic        Done;
    logic        Ready;

    modport master (output start, stop, A, B, input Mul_f, Done, Ready);
    modport slave  (input start, stop, A, B, output Mul_f, Done, Ready);
endinterface

// File: rtl/multiplier_frac.sv
// Sequential 24x24 shift-add significand multiplier, one multiplier bit per cycle.
// Cleared whenever start is low; Finish flags the last of 24 iterations.
module multiplier_frac
    import fpu_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start,
    input  logic [MANT_W-1:0]   m_a,
    input  logic [MANT_W-1:0]   m_b,
    output logic                finish,
    output logic [24:0]         prod_top
);

    logic [4:0]  cnt;
    logic [47:0] acc;

    assign finish   = start && (cnt == 5'd23);
    assign prod_top = acc[47:23];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= 5'd0;
            acc <= 48'd0;
        end else if (!start) begin
            cnt <= 5'd0;
            acc <= 48'd0;
        end else begin
            if (m_a[cnt])
                acc <= acc + ({24'd0, m_b} << cnt);
            cnt <= cnt + 5'd1;
        end
    end

endmodule

// File: rtl/mul_f_32bit.sv
// Multi-cycle binary32 multiplier: start sampled in IDLE, Done 26 cycles later, result the cycle after.
// stop aborts only during MANT; denormals flush to zero, product is truncated.
module mul_f_32bit
    import fpu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    mul_f_32bit_if.slave    bus
);

    state_t      state;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        finish;
    logic [24:0] prod_top;

    multiplier_frac u_frac (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start    (state == MANT),
        .m_a      ({1'b1, op_a[22:0]}),
        .m_b      ({1'b1, op_b[22:0]}),
        .finish   (finish),
        .prod_top (prod_top)
    );

    logic [7:0]        exp_a, exp_b;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              sgn, norm_n;
    logic [22:0]       frac;
    logic [8:0]        exp_sum;
    logic signed [9:0] e;
    logic [31:0]       result;

    always_comb begin
        exp_a  = op_a[30:23];
        exp_b  = op_b[30:23];
        a_nan  = (exp_a == EXP_MAX) && (op_a[22:0] != 23'd0);
        b_nan  = (exp_b == EXP_MAX) && (op_b[22:0] != 23'd0);
        a_inf  = (exp_a == EXP_MAX) && (op_a[22:0] == 23'd0);
        b_inf  = (exp_b == EXP_MAX) && (op_b[22:0] == 23'd0);
        a_zero = (exp_a == 8'd0);
        b_zero = (exp_b == 8'd0);
        sgn    = op_a[31] ^ op_b[31];

        // prod_top[24] is product bit 47: a product in [2,4) shifts one place further.
        norm_n = prod_top[24];
        frac   = norm_n ? prod_top[23:1] : prod_top[22:0];

        exp_sum = add8(exp_a, exp_b, 1'b0);
        e = $signed({1'b0, exp_sum}) - $signed({2'b00, BIAS}) + $signed({9'd0, norm_n});

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            result = QNAN;
        else if (a_inf || b_inf)
            result = {sgn, EXP_MAX, 23'd0};
        else if (a_zero || b_zero)
            result = {sgn, 31'd0};
        else if (e >= 10'sd255)
            result = {sgn, EXP_MAX, 23'd0};
        else if (e <= 10'sd0)
            result = {sgn, 31'd0};
        else
            result = {sgn, e[7:0], frac};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            bus.Mul_f <= 32'd0;
            bus.Done  <= 1'b0;
            bus.Ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= FETCH;
                        bus.Ready <= 1'b0;
                    end
                end
                FETCH: begin
                    op_a  <= bus.A;
                    op_b  <= bus.B;
                    state <= MANT;
                end
                MANT: begin
                    // Completion wins over a same-cycle abort.
                    if (finish) begin
                        state    <= WRITE;
                        bus.Done <= 1'b1;
                    end else if (bus.stop) begin
                        state     <= IDLE;
                        bus.Ready <= 1'b1;
                    end
                end
                WRITE: begin
                    state     <= IDLE;
                    bus.Mul_f <= result;
                    bus.Done  <= 1'b0;
                    bus.Ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_f_32bit.sv
// Directed bench for mul_f_32bit: expected products queued at issue, compared at result.
module tb_mul_f_32bit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul_f_32bit_if bus();

    mul_f_32bit dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int          pass_cnt = 0;
    int          total    = 0;
    int          jc       = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: got %h want %h", tag, obs, expv);
    endtask

    // Leaves the bench at the falling edge of the FETCH cycle (jc = 1).
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        jc = 1;
        check("ready_drop", 32'(bus.Ready), 32'd0);
    endtask

    task automatic step_to(input int t);
        while (jc < t) begin
            @(negedge clk);
            jc++;
        end
    endtask

    task automatic finish_op(input string tag);
        logic [31:0] expv;
        while (jc < 60 && bus.Done !== 1'b1) begin
            @(negedge clk);
            jc++;
        end
        check({tag, "_done_cycle"}, 32'(jc), 32'd26);
        @(negedge clk);
        jc++;
        if (exp_q.size() == 0) begin
            total++;
            $error("FAIL %s_scoreboard: got empty queue want entry", tag);
        end else begin
            expv = exp_q.pop_front();
            check({tag, "_result"}, bus.Mul_f, expv);
        end
        check({tag, "_ready_back"}, 32'(bus.Ready), 32'd1);
        check({tag, "_done_low"}, 32'(bus.Done), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv);
        exp_q.push_back(expv);
        start_op(a, b);
        finish_op(tag);
    endtask

    initial begin
        int dones;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        #12;
        check("rst_ready", 32'(bus.Ready), 32'd1);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_mul", bus.Mul_f, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("two_x_three", 32'h40000000, 32'h40400000, 32'h40C00000);
        run_op("norm_hi",     32'h3FC00000, 32'h3FC00000, 32'h40100000);
        run_op("neg",         32'hC0200000, 32'h40800000, 32'hC1200000);
        run_op("neg_zero",    32'h80000000, 32'h40A00000, 32'h80000000);
        run_op("denorm",      32'h00000001, 32'h3F800000, 32'h00000000);
        run_op("overflow",    32'h7F000000, 32'h7F000000, 32'h7F800000);
        run_op("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000);
        run_op("underflow",   32'h00800000, 32'h00800000, 32'h00000000);
        run_op("truncate",    32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);
        run_op("nan_in",      32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        run_op("inf_neg",     32'h7F800000, 32'hC0000000, 32'hFF800000);
        run_op("one_x_one",   32'h3F800000, 32'h3F800000, 32'h3F800000);
        run_op("prior",       32'h40000000, 32'h40400000, 32'h40C00000);

        // Abort on the 10th MANT cycle.
        start_op(32'h3FC00000, 32'h3FC00000);
        step_to(11);
        bus.stop = 1'b1;
        step_to(12);
        bus.stop = 1'b0;
        check("abort_ready", 32'(bus.Ready), 32'd1);
        check("abort_done", 32'(bus.Done), 32'd0);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_hold", bus.Mul_f, 32'h40C00000);

        // stop on the last MANT cycle loses to completion.
        exp_q.push_back(32'h40100000);
        start_op(32'h3FC00000, 32'h3FC00000);
        step_to(25);
        bus.stop = 1'b1;
        step_to(26);
        bus.stop = 1'b0;
        check("stop_finish_done", 32'(bus.Done), 32'd1);
        finish_op("stop_finish");

        // Reset in the middle of MANT.
        start_op(32'h40000000, 32'h40400000);
        step_to(10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mul", bus.Mul_f, 32'd0);
        check("mid_rst_ready", 32'(bus.Ready), 32'd1);
        check("mid_rst_done", 32'(bus.Done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Operand changes and a stray start during MANT must not disturb the op.
        exp_q.push_back(32'h40C00000);
        start_op(32'h40000000, 32'h40400000);
        step_to(3);
        bus.A = 32'h7F800000;
        bus.B = 32'h00000000;
        step_to(8);
        bus.start = 1'b1;
        step_to(9);
        bus.start = 1'b0;
        finish_op("after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mul_f_32bit.md
Name: mul_f_32bit

Overview:
- Multi-cycle IEEE-754 binary32 multiplier for the FP32 FPU; the multiplicative counterpart of the sequential FP divider.
- Uses the same start/stop/Ready/Done handshake, so the FPU issue logic drives both units identically.
- Mantissa product is formed by a sequential 24x24 shift-add engine, one bit per cycle. The result is normalized, truncated and written to a result register.
- Inputs that are zero, infinity, NaN or denormal go through the full sequence, so latency is constant.

Parameters:
- None. Format is fixed at binary32: 24-bit significand including hidden 1, exponent bias 127.

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- stop  input  1  abort; honoured only in MANT
- A  input  32  operand A (binary32)
- B  input  32  operand B (binary32)
- Mul_f  output  32  registered product; holds until next WRITE
- Done  output  1  high exactly during the WRITE cycle
- Ready  output  1  high while in IDLE

Behaviour:
- One clock, clk_i; rst_ni asynchronous, active-low. Reset forces state=IDLE, fetched operands=0, Mul_f=0, internal counter/accumulator=0. Done=0 and Ready=1 immediately.
- FSM states IDLE, FETCH, MANT, WRITE:
  - IDLE: on start go to FETCH, else stay.
  - FETCH: latch A and B; always go to MANT.
  - MANT: if Finish go to WRITE; else if stop go to IDLE; else stay. Finish has priority over stop in the same cycle.
  - WRITE: go to IDLE.
- start outside IDLE is ignored. stop outside MANT is ignored. A/B changes after FETCH have no effect.
- Latency: start sampled at edge k; FETCH in cycle k+1; MANT in cycles k+2..k+25 (24 cycles); WRITE/Done in k+26. Mul_f is loaded at the edge ending WRITE and is valid from k+27. Ready returns in k+27.
- Mantissa engine, multiplier_frac:
  - While its start input (=MANT) is low, counter and 48-bit accumulator are cleared.
  - While high, iteration c (0..23) adds (mB if bit c of mA) << c.
  - Finish=1 when c==23; the accumulator holds the full product from the next cycle (WRITE).
- Normalization (P = 48-bit product):
  - If P[47]: frac = P[46:24], n=1.
  - Else: frac = P[45:23], n=0.
  - Truncation; no rounding.
- Exponent: 10-bit signed e = expA + expB - 127 + n.
- Sign = A[31]^B[31].
- Special cases, evaluated in WRITE, in priority order:
  1. Either operand NaN (exp=255, frac!=0), or inf x zero: Mul_f = 0x7FC00000.
  2. Either operand inf: signed inf, {s,8'hFF,23'b0}.
  3. Either exp=0 (zero/denormal flushed): signed zero.
  4. e>=255: signed inf.
  5. e<=0: signed zero.
  6. Otherwise: {s, e[7:0], frac}.
- Stop in MANT: return to IDLE next cycle, no Done, Mul_f unchanged, engine cleared.
- Reset mid-operation: immediate IDLE, Mul_f=0; no Done is produced.

Decomposition:
- Shared fpu_pkg holds:
  - state enum {IDLE, FETCH, MANT, WRITE}, also used by the divider
  - BIAS=8'd127, EXP_MAX=8'hFF, QNAN=32'h7FC00000, MANT_W=24
- One sub-module, multiplier_frac: sequential 24x24->48 shift-add with counter and Finish.
- Exponent add/subtract reuses the existing 8-bit full adder, sign-extended into the 10-bit check.

Test Plan:
- A=0x40000000 (2.0), B=0x40400000 (3.0), start pulse -> Ready drops next cycle; Done high 26 cycles after start sample; Mul_f=0x40C00000 the following cycle.
- A=0x3FC00000, B=0x3FC00000 (1.5x1.5) -> P[47]=1 normalization path; Mul_f=0x40100000. Then A=0xC0200000, B=0x40800000 -> 0xC1200000.
- A=0x80000000, B=0x40A00000 -> 0x80000000. A=0x00000001 (denormal), B=0x3F800000 -> 0x00000000.
- A=0x7F000000, B=0x7F000000 -> overflow 0x7F800000. A=0x7F800000, B=0x00000000 -> 0x7FC00000. A=0x00800000, B=0x00800000 -> underflow 0x00000000.
- Prior result 0x40C00000; new op; assert stop on the 10th MANT cycle -> IDLE next cycle, Ready=1, Done never asserts, Mul_f stays 0x40C00000. Also stop together with Finish on the last MANT cycle -> WRITE wins.
- Drop rst_ni mid-MANT -> Mul_f=0, Ready=1, Done=0 immediately. After release, a new 2.0x3.0 op completes with normal latency. A start pulse during MANT is ignored and does not shorten or restart the operation.
